// File: rtl/tlul_dev_responder.sv
// TL-UL device-side responder: one outstanding A-channel request bridged to a req/gnt/rvalid backend.
// Optional macro TLUL_DEV_ADDR_RANGE_CHECK_EN rejects byte offsets >= ADDR_LIMIT.
package tlul_pkg;
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_dev_responder
  import tlul_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_1000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic          be_req_o,
  output logic          be_we_o,
  output logic [AW-1:0] be_addr_o,
  output logic [31:0]   be_wdata_o,
  output logic [3:0]    be_be_o,
  input  logic          be_gnt_i,
  input  logic          be_rvalid_i,
  input  logic [31:0]   be_rdata_i,
  input  logic          be_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_e state_q, state_d;

  logic [2:0]    op_q;
  logic [1:0]    size_q;
  logic [7:0]    src_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   cnt_q;

  logic        accept;
  logic        req_err;
  logic        range_err;
  logic        opcode_ok;
  logic [31:0] cnt_inc;
  logic        timeout;
  logic        capture;
  logic        unused_sig;

  assign unused_sig = ^{tl_i.a_param, tl_i.a_address, ADDR_LIMIT};

  assign accept = tl_i.a_valid && (state_q == ST_IDLE);

`ifdef TLUL_DEV_ADDR_RANGE_CHECK_EN
  assign range_err = (tl_i.a_address >= ADDR_LIMIT);
`else
  assign range_err = 1'b0;
`endif

  assign opcode_ok = (tl_i.a_opcode == GET) || (tl_i.a_opcode == PUT_FULL_DATA) ||
                     (tl_i.a_opcode == PUT_PARTIAL_DATA);

  assign req_err = !opcode_ok
                || (tl_i.a_address[1:0] != 2'b00)
                || (tl_i.a_size > 2'd2)
                || ((tl_i.a_opcode == PUT_FULL_DATA) && (tl_i.a_mask != 4'hF))
                || range_err;

  // Fires on the increment that brings the count to TIMEOUT_CYCLES-1, so the
  // error response appears TIMEOUT_CYCLES cycles after the grant cycle.
  assign cnt_inc = cnt_q + 32'd1;
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == ST_WAIT) && !be_rvalid_i &&
                   (cnt_inc >= TO_LAST);

  assign capture = be_rvalid_i &&
                   (((state_q == ST_REQ) && be_gnt_i) || (state_q == ST_WAIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_err ? ST_RESP : ST_REQ;
      ST_REQ:  if (be_gnt_i) state_d = be_rvalid_i ? ST_RESP : ST_WAIT;
      ST_WAIT: if (be_rvalid_i || timeout) state_d = ST_RESP;
      ST_RESP: if (tl_i.d_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= '0;
      size_q  <= '0;
      src_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        op_q    <= tl_i.a_opcode;
        size_q  <= tl_i.a_size;
        src_q   <= tl_i.a_source;
        we_q    <= (tl_i.a_opcode != GET);
        addr_q  <= {tl_i.a_address[AW-1:2], 2'b00};
        wdata_q <= tl_i.a_data;
        mask_q  <= tl_i.a_mask;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if ((state_q == ST_REQ) && be_gnt_i) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_inc;
      end
      if (capture) begin
        rdata_q <= (op_q == GET) ? be_rdata_i : '0;
        err_q   <= be_err_i;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (state_q == ST_IDLE);
    tl_o.d_valid  = (state_q == ST_RESP);
    tl_o.d_opcode = (op_q == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
    tl_o.d_size   = size_q;
    tl_o.d_source = src_q;
    tl_o.d_data   = rdata_q;
    tl_o.d_error  = err_q;
    be_req_o      = (state_q == ST_REQ);
    be_we_o       = we_q;
    be_addr_o     = addr_q;
    be_wdata_o    = wdata_q;
    be_be_o       = mask_q;
  end

endmodule

// File: tb/tb_tlul_dev_responder.sv
// Directed, table-driven bench for tlul_dev_responder with TIMEOUT_CYCLES=4.
module tb_tlul_dev_responder;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        be_req_o, be_we_o;
  logic [31:0] be_addr_o, be_wdata_o;
  logic [3:0]  be_be_o;
  logic        be_gnt_i, be_rvalid_i, be_err_i;
  logic [31:0] be_rdata_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  tlul_dev_responder #(
    .AW(32),
    .TIMEOUT_CYCLES(4),
    .ADDR_LIMIT(32'h0000_1000)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .tl_i(tl_i),
    .tl_o(tl_o),
    .be_req_o(be_req_o),
    .be_we_o(be_we_o),
    .be_addr_o(be_addr_o),
    .be_wdata_o(be_wdata_o),
    .be_be_o(be_be_o),
    .be_gnt_i(be_gnt_i),
    .be_rvalid_i(be_rvalid_i),
    .be_rdata_i(be_rdata_i),
    .be_err_i(be_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [7:0]  src;
    int          rv_delay;
    logic [31:0] rdata;
    logic        berr;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [2:0]  exp_dop;
    logic [31:0] exp_ddata;
    logic        exp_derr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'h0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk_i);
    tl_i.d_ready = 1'b1;
    drive_a(v.op, v.addr, v.size, v.mask, v.wdata, v.src);
    check({tag, "_a_ready_idle"}, tl_o.a_ready, 1'b1);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    check({tag, "_be_req"}, be_req_o, v.exp_req);
    if (be_req_o) begin
      check({tag, "_be_we"}, be_we_o, v.exp_we);
      check({tag, "_be_addr"}, be_addr_o, v.addr);
      check({tag, "_be_wdata"}, be_wdata_o, v.wdata);
      check({tag, "_be_be"}, be_be_o, v.exp_be);
      be_gnt_i = 1'b1;
      if (v.rv_delay == 0) begin
        be_rvalid_i = 1'b1;
        be_rdata_i  = v.rdata;
        be_err_i    = v.berr;
      end
      @(negedge clk_i);
      be_gnt_i    = 1'b0;
      be_rvalid_i = 1'b0;
      be_err_i    = 1'b0;
      if (v.rv_delay > 0) begin
        for (int i = 0; i < v.rv_delay - 1; i++) @(negedge clk_i);
        check({tag, "_wait_no_dvalid"}, tl_o.d_valid, 1'b0);
        be_rvalid_i = 1'b1;
        be_rdata_i  = v.rdata;
        be_err_i    = v.berr;
        @(negedge clk_i);
        be_rvalid_i = 1'b0;
        be_err_i    = 1'b0;
      end
    end
    check({tag, "_d_valid"}, tl_o.d_valid, 1'b1);
    check({tag, "_a_ready_busy"}, tl_o.a_ready, 1'b0);
    check({tag, "_d_opcode"}, tl_o.d_opcode, v.exp_dop);
    check({tag, "_d_data"}, tl_o.d_data, v.exp_ddata);
    check({tag, "_d_error"}, tl_o.d_error, v.exp_derr);
    check({tag, "_d_source"}, tl_o.d_source, v.src);
    check({tag, "_d_size"}, tl_o.d_size, v.size);
    @(negedge clk_i);
    check({tag, "_d_valid_done"}, tl_o.d_valid, 1'b0);
    check({tag, "_a_ready_back"}, tl_o.a_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    tl_d2h_t exp_d;
    exp_d = '0;
    exp_d.a_ready = 1'b1;
    check({tag, "_tl_o"}, tl_o, exp_d);
    check({tag, "_be_req"}, be_req_o, 1'b0);
    check({tag, "_be_we"}, be_we_o, 1'b0);
    check({tag, "_be_addr"}, be_addr_o, 32'h0);
    check({tag, "_be_wdata"}, be_wdata_o, 32'h0);
    check({tag, "_be_be"}, be_be_o, 4'h0);
  endtask

  initial begin
    tl_d2h_t exp_to;

    //        op                addr          sz mask  wdata         src    dly rdata         berr req we be    dop              ddata         derr
    vecs[0]  = '{GET,              32'h10,   2, 4'hF, 32'h0,        8'h11, 1, 32'hCAFEF00D, 0, 1, 0, 4'hF, ACCESS_ACK_DATA, 32'hCAFEF00D, 0};
    vecs[1]  = '{PUT_FULL_DATA,    32'h20,   2, 4'hF, 32'h12345678, 8'h22, 0, 32'hDEADBEEF, 0, 1, 1, 4'hF, ACCESS_ACK,      32'h0,        0};
    vecs[2]  = '{PUT_PARTIAL_DATA, 32'h24,   2, 4'h3, 32'h0000A5A5, 8'h03, 2, 32'h11112222, 0, 1, 1, 4'h3, ACCESS_ACK,      32'h0,        0};
    vecs[3]  = '{GET,              32'h22,   2, 4'hF, 32'h0,        8'h04, 0, 32'h0,        0, 0, 0, 4'h0, ACCESS_ACK_DATA, 32'h0,        1};
    vecs[4]  = '{GET,              32'h30,   3, 4'hF, 32'h0,        8'h05, 0, 32'h0,        0, 0, 0, 4'h0, ACCESS_ACK_DATA, 32'h0,        1};
    vecs[5]  = '{PUT_FULL_DATA,    32'h34,   2, 4'h7, 32'hAAAA5555, 8'h06, 0, 32'h0,        0, 0, 0, 4'h0, ACCESS_ACK,      32'h0,        1};
    vecs[6]  = '{3'h5,             32'h38,   2, 4'hF, 32'h0,        8'h07, 0, 32'h0,        0, 0, 0, 4'h0, ACCESS_ACK,      32'h0,        1};
    vecs[7]  = '{GET,              32'h3C,   2, 4'hF, 32'h0,        8'h08, 0, 32'h00000055, 1, 1, 0, 4'hF, ACCESS_ACK_DATA, 32'h00000055, 1};
    vecs[8]  = '{GET,              32'h40,   0, 4'h1, 32'h0,        8'h09, 1, 32'h000000AB, 0, 1, 0, 4'h1, ACCESS_ACK_DATA, 32'h000000AB, 0};
    vecs[9]  = '{PUT_PARTIAL_DATA, 32'h44,   2, 4'hC, 32'h99990000, 8'h0B, 1, 32'h00009999, 1, 1, 1, 4'hC, ACCESS_ACK,      32'h0,        1};
`ifdef TLUL_DEV_ADDR_RANGE_CHECK_EN
    vecs[10] = '{GET,              32'h1000, 2, 4'hF, 32'h0,        8'h0A, 0, 32'h00000077, 0, 0, 0, 4'h0, ACCESS_ACK_DATA, 32'h0,        1};
`else
    vecs[10] = '{GET,              32'h1000, 2, 4'hF, 32'h0,        8'h0A, 0, 32'h00000077, 0, 1, 0, 4'hF, ACCESS_ACK_DATA, 32'h00000077, 0};
`endif
    vecs[11] = '{GET,              32'hFFC,  2, 4'hF, 32'h0,        8'h0C, 0, 32'h00000088, 0, 1, 0, 4'hF, ACCESS_ACK_DATA, 32'h00000088, 0};

    rst_ni      = 1'b0;
    tl_i        = '0;
    be_gnt_i    = 1'b0;
    be_rvalid_i = 1'b0;
    be_rdata_i  = '0;
    be_err_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Timeout with D-channel backpressure.
    @(negedge clk_i);
    tl_i.d_ready = 1'b0;
    drive_a(GET, 32'h50, 2'd2, 4'hF, 32'h0, 8'h5A);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    check("to_be_req", be_req_o, 1'b1);
    be_gnt_i = 1'b1;
    @(negedge clk_i);
    be_gnt_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("to_early_%0d", i), tl_o.d_valid, 1'b0);
      @(negedge clk_i);
    end
    exp_to = '0;
    exp_to.d_valid  = 1'b1;
    exp_to.d_opcode = ACCESS_ACK_DATA;
    exp_to.d_size   = 2'd2;
    exp_to.d_source = 8'h5A;
    exp_to.d_error  = 1'b1;
    check("to_resp", tl_o, exp_to);
    be_rvalid_i = 1'b1;
    be_rdata_i  = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      be_rvalid_i = 1'b0;
      check($sformatf("to_hold_%0d", i), tl_o, exp_to);
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk_i);
    check("to_done_dvalid", tl_o.d_valid, 1'b0);
    check("to_done_aready", tl_o.a_ready, 1'b1);

    // Reset while waiting for the backend response.
    @(negedge clk_i);
    drive_a(GET, 32'h60, 2'd2, 4'hF, 32'h0, 8'h66);
    @(negedge clk_i);
    tl_i.a_valid = 1'b0;
    check("rw_be_req", be_req_o, 1'b1);
    be_gnt_i = 1'b1;
    @(negedge clk_i);
    be_gnt_i = 1'b0;
    rst_ni   = 1'b0;
    #1;
    check_reset_outputs("rw");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    be_rvalid_i = 1'b1;
    be_rdata_i  = 32'h00000BAD;
    @(negedge clk_i);
    be_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rw_no_resp_%0d", i), tl_o.d_valid, 1'b0);
      @(negedge clk_i);
    end
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
